bram_port_arbiter: RTL
======================

// Module: bram_port_arbiter
// PURPOSE
// - Shares the single-port undistort frame BRAM between three requesters:
//   0 = bram_reader (interpolator pixel fetch), 1 = bram_writer (input frame load),
//   2 = output transfer (result readout).
// - Grants bursts of accesses, muxes address, write-enable and write data onto the BRAM port.
// - Returns read data to the requester that issued each read, tagged by a latency pipeline.
// - Sits between the pipeline stages sequenced by the control FSM and the frame BRAM.
// PARAMETERS
// - ADDR_W     17  BRAM address width (320*240 = 76800 words).
// - DATA_W     8   pixel width.
// - RD_LAT     2   BRAM read latency, cycles from bram_en to valid bram_rdata (>=1).
// - MAX_BURST  16  maximum beats per grant before forced release (>=1).
// PORTS
// - clk         in   1           system clock, all logic on rising edge
// - rst         in   1           synchronous, active-high reset
// - req         in   3           per-requester access request, held until accepted
// - rw          in   3           per-requester 1=write, 0=read (valid with req)
// - last        in   3           per-requester final beat of burst (valid with req)
// - addr        in   3*ADDR_W    per-requester address, requester i at [i*ADDR_W +: ADDR_W]
// - wdata       in   3*DATA_W    per-requester write data, same packing
// - gnt         out  3           one-hot beat accept; beat transfers when req[i]&&gnt[i]
// - rvalid      out  3           one-hot read-return strobe
// - rdata       out  DATA_W      read data, valid when any rvalid bit is high
// - bram_en     out  1           BRAM port enable
// - bram_we     out  1           BRAM write enable
// - bram_addr   out  ADDR_W      BRAM address
// - bram_wdata  out  DATA_W      BRAM write data
// - bram_rdata  in   DATA_W      BRAM read data
// BEHAVIOUR
// - States: IDLE, BUSY. Registers: owner[1:0], beat_cnt, rr_ptr, RD_LAT-deep {valid,id} pipe.
// - Reset values: IDLE; gnt=0, rvalid=0, bram_en=0, bram_we=0; pipe cleared;
//   rr_ptr=2; owner=0; beat_cnt=0.
// - IDLE: if any req, select winner and register it as owner -> BUSY; gnt=0 in IDLE.
//   Grant latency is 1 cycle from req seen in IDLE.
// - BUSY:
//   - gnt[owner] = req[owner], driven combinationally from the registered owner.
//   - Accepted beat drives bram_en=1, bram_we=rw[owner],
//     bram_addr/bram_wdata = owner slice, in the same cycle.
//   - No beat: bram_en=0, bram_we=0, bram_addr/bram_wdata hold last value.
// - Release (-> IDLE, one bubble cycle) when any of:
//   - accepted beat with last[owner]=1;
//   - accepted beat count reaches MAX_BURST;
//   - req[owner]=0 in BUSY (owner abandoned).
//   The releasing beat itself is still performed.
// - Forced release at MAX_BURST: the requester keeps req high and re-competes in IDLE.
// - beat_cnt: cleared on entering BUSY, +1 per accepted beat, never exceeds MAX_BURST.
// - Read return:
//   - Each accepted read pushes {1,owner} into the pipe.
//   - Writes and idle cycles push {0,x}.
//   - At pipe output, rvalid[id]=1 and rdata=bram_rdata (passed through, unregistered).
//   - Reads in flight still return to their issuer after release or a new grant.
// - Write then read to the same address in consecutive beats: BRAM native read-first/
//   write-first semantics apply; the arbiter adds no forwarding.
// - Reset mid-burst: grant dropped immediately; in-flight reads discarded (no rvalid);
//   the owner must re-request.
// - gnt and rvalid are always one-hot or zero; never more than one BRAM access per cycle.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined: IDLE winner is the first requesting index after rr_ptr
//   (cyclic 0,1,2); rr_ptr <= winner on each grant. Reset rr_ptr=2, so requester 0 has
//   first priority.
// - Undefined: fixed priority 0 > 1 > 2; rr_ptr unused (may be optimised away).
// TESTING
// - Reset, no req -> gnt=0, bram_en=0, rvalid=0 for 10 cycles.
// - Req0 read burst, addr 100..103, last on 4th beat -> gnt[0] from cycle 1 for 4 beats;
//   rvalid[0] x4 beginning RD_LAT cycles after the first beat; data matches BRAM; IDLE after.
// - req1 write burst of 20 beats, no last, MAX_BURST=16 -> 16 beats, 1-cycle bubble,
//   regrant, 4 beats.
// - req0, req1 and req2 all asserted together, single-beat each:
//   fixed priority -> order 0,1,2;
//   ARB_ROUND_ROBIN_EN with requests re-asserted -> 0,1,2,0,1,2.
// - Owner 2 issues read then last; owner 0 granted next -> owner 2's rvalid[2] arrives
//   correctly during owner 0's burst.
// - rst pulsed 1 cycle mid-read-burst with 2 reads in flight -> no rvalid afterwards;
//   gnt=0 next cycle.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the frame BRAM arbiter.
// Three requesters: 0 = bram_reader, 1 = bram_writer, 2 = output transfer.
// Per-requester fields are packed so that requester i sits at [i*W +: W].
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic [2:0]             req;
    logic [2:0]             rw;
    logic [2:0]             last;
    logic [2:0][ADDR_W-1:0] addr;
    logic [2:0][DATA_W-1:0] wdata;
    logic [2:0]             gnt;
    logic [2:0]             rvalid;
    logic [DATA_W-1:0]      rdata;

    modport master (output req, rw, last, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, rw, last, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// Arbiter sharing the single-port undistort frame BRAM between three requesters.
// Grants bursts, muxes the owner's beat onto the BRAM port and steers read data
// back to the issuing requester through an RD_LAT-deep {valid,id} pipe.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin winner selection in IDLE;
// when undefined the winner is fixed priority 0 > 1 > 2.

// Per-requester grant / read-return decode.
module bram_port_arbiter_lane #(
    parameter logic [1:0] IDX = 2'd0
) (
    input  logic       busy,
    input  logic [1:0] owner,
    input  logic       req,
    input  logic       out_vld,
    input  logic [1:0] out_id,
    output logic       gnt,
    output logic       rvalid
);
    // Grant follows the owner's request; rvalid follows the pipe output tag.
    always_comb begin
        gnt    = busy && (owner == IDX) && req;
        rvalid = out_vld && (out_id == IDX);
    end
endmodule

module bram_port_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    bram_port_arbiter_if.slave  rq,
    output logic                bram_en,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wdata,
    input  logic [DATA_W-1:0]   bram_rdata
);
    localparam int NUM_REQ = 3;
    localparam int CNT_W   = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          winner;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                beat;
    logic                rd_push;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0][1:0] id_pipe;
    logic [NUM_REQ-1:0]  gnt_w, rvalid_w;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q;
    logic [1:0] cand;

    // Round-robin: first requesting index after rr_ptr wins (scan backwards so the nearest wins).
    always_comb begin
        winner = rr_ptr_q;
        cand   = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (rq.req[cand]) winner = cand;
        end
    end

    // Pointer tracks the most recent winner; reset to 2 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst)                               rr_ptr_q <= 2'd2;
        else if (state_q == IDLE && |rq.req)   rr_ptr_q <= winner;
    end
`else
    // Fixed priority 0 > 1 > 2.
    always_comb begin
        winner = 2'd2;
        if (rq.req[1]) winner = 2'd1;
        if (rq.req[0]) winner = 2'd0;
    end
`endif

    // A beat transfers when the owner requests in BUSY; reset kills it at once.
    always_comb begin
        beat    = (state_q == BUSY) && rq.req[owner_q] && !rst;
        rd_push = beat && !rq.rw[owner_q];
    end

    // Next-state logic: claim an owner in IDLE, release on last / full burst / abandon.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|rq.req) begin
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (beat) beat_cnt_d = beat_cnt_q + 1'b1;
                if (!rq.req[owner_q] || rq.last[owner_q] ||
                    beat_cnt_q == CNT_W'(MAX_BURST - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner and burst counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Remember the last beat's address/data so the port holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (beat) begin
            addr_q  <= rq.addr[owner_q];
            wdata_q <= rq.wdata[owner_q];
        end
    end

    // BRAM port mux: live owner slice on a beat, held value otherwise.
    always_comb begin
        bram_en    = beat;
        bram_we    = beat && rq.rw[owner_q];
        bram_addr  = beat ? rq.addr[owner_q]  : addr_q;
        bram_wdata = beat ? rq.wdata[owner_q] : wdata_q;
    end

    // Read-return tag pipe; stage RD_LAT-1 lines up with valid bram_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= rd_push;
            id_pipe[0]  <= owner_q;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        bram_port_arbiter_lane #(.IDX(2'(i))) u_lane (
            .busy    ((state_q == BUSY) && !rst),
            .owner   (owner_q),
            .req     (rq.req[i]),
            .out_vld (vld_pipe[RD_LAT-1] && !rst),
            .out_id  (id_pipe[RD_LAT-1]),
            .gnt     (gnt_w[i]),
            .rvalid  (rvalid_w[i])
        );
    end

    // Drive the requester bus.
    always_comb begin
        rq.gnt    = gnt_w;
        rq.rvalid = rvalid_w;
        rq.rdata  = bram_rdata;
    end
endmodule
